// File: rtl/tia_playfield_sequencer.sv
// tia_playfield_sequencer: scanline counter and serial playfield bit generator with pixel-aligned register commits
module tia_playfield_sequencer #(
  parameter int H_TOTAL = 228,
  parameter int H_BLANK = 68
) (
  input  logic       clk,
  input  logic       i_r,
  input  logic [7:0] i_d,
  input  logic       i_wr_pf0,
  input  logic       i_wr_pf1,
  input  logic       i_wr_pf2,
  input  logic       i_ref,
  output logic [7:0] o_hcount,
  output logic       o_hblank,
  output logic       o_eol,
  output logic       o_pf
);
  logic [7:0]  r_hcount;
  logic [7:0]  r_pend [3];
  logic [7:0]  r_act [3];
  logic [2:0]  r_flag;
  logic        r_ref_act;
  logic [2:0]  w_wr;
  logic        w_commit;
  logic [7:0]  w_x;
  logic [5:0]  w_p;
  logic [4:0]  w_q;
  logic [7:0]  w_pf1_rev;
  logic [23:0] w_bits;
  assign w_wr = {i_wr_pf2, i_wr_pf1, i_wr_pf0};
  assign w_commit = &r_hcount[1:0];
  assign o_hcount = r_hcount;
  assign o_hblank = r_hcount < 8'(H_BLANK);
  assign o_eol = r_hcount == 8'(H_TOTAL - 1);
  assign w_x = r_hcount - 8'(H_BLANK);
  assign w_p = 6'(w_x >> 2);
  assign w_q = w_p < 6'd20 ? w_p[4:0] : r_ref_act ? 5'(6'd39 - w_p) : 5'(w_p - 6'd20);
  for (genvar i = 0; i < 8; i++) assign w_pf1_rev[i] = r_act[1][7-i];
  // Pixel order: PF0[7:4] low-to-high, PF1 high-to-low, PF2 low-to-high; PF0[3:0] sits below and is never selected
  assign w_bits = {r_act[2], w_pf1_rev, r_act[0]};
  assign o_pf = !o_hblank && w_bits[w_q + 5'd4];
  // Counter, reflect sample at the start of the right half, and latch-then-commit on pixel boundaries
  always_ff @(posedge clk)
    if (i_r) begin
      r_hcount <= '0;
      r_flag <= '0;
      r_ref_act <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_pend[k] <= '0;
        r_act[k] <= '0;
      end
    end else begin
      r_hcount <= o_eol ? '0 : r_hcount + 8'd1;
      if (r_hcount == 8'(H_BLANK + 79)) r_ref_act <= i_ref;
      for (int k = 0; k < 3; k++)
        if (w_commit) begin
          r_act[k] <= w_wr[k] ? i_d : r_flag[k] ? r_pend[k] : r_act[k];
          r_flag[k] <= 1'b0;
        end else if (w_wr[k]) begin
          r_pend[k] <= i_d;
          r_flag[k] <= 1'b1;
        end
    end
endmodule
